// File: rtl/pipe_hazard_scoreboard.sv
// Per-register issue scoreboard at ID: stalls on unresolved producers and picks forward stages.
// Latency: stall and fwd_sel are combinational from ID inputs and registered state; state updates next edge.
// Backpressure: stall holds the ID instruction; nothing is recorded until it is accepted without flush.
module pipe_hazard_scoreboard #(
    parameter int NREG       = 32,
    parameter int AW         = $clog2(NREG),
    parameter int PIPE_DEPTH = 3,
    parameter int MAX_LAT    = 3,
    parameter int LW         = $clog2(MAX_LAT + 1),
    parameter int FW         = $clog2(PIPE_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic          flush,
    input  logic [AW-1:0] src_a,
    input  logic          use_a,
    input  logic [AW-1:0] src_b,
    input  logic          use_b,
    input  logic [AW-1:0] dst,
    input  logic          dst_we,
    input  logic [LW-1:0] lat,
    output logic          stall,
    output logic [FW-1:0] fwd_sel_a,
    output logic [FW-1:0] fwd_sel_b,
    output logic [AW:0]   pending_cnt,
    output logic [31:0]   stall_cycles
);

    logic [LW-1:0]   cnt [NREG];
    logic [FW-1:0]   age [NREG];
    logic [NREG-1:0] pend;

    logic          hit_a;
    logic          hit_b;
    logic          accept;
    logic [LW-1:0] cnt_init;

    assign hit_a  = use_a && (src_a != '0) && (cnt[src_a] != '0);
    assign hit_b  = use_b && (src_b != '0) && (cnt[src_b] != '0);
    assign stall  = issue_valid && (hit_a || hit_b);
    assign accept = issue_valid && !stall && !flush;

    // lat = 0 behaves like a single-cycle ALU result
    assign cnt_init = (lat == '0) ? '0 : lat - LW'(1);

    assign fwd_sel_a = (use_a && (src_a != '0) && pend[src_a]) ? age[src_a] : '0;
    assign fwd_sel_b = (use_b && (src_b != '0) && pend[src_b]) ? age[src_b] : '0;

    always_comb begin
        pending_cnt = '0;
        for (int r = 1; r < NREG; r++) begin
            pending_cnt = pending_cnt + (AW + 1)'(pend[r]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
                age[r] <= '0;
            end
            pend         <= '0;
            stall_cycles <= '0;
        end else begin
            if (stall && !flush && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            // register 0 is never tracked, so its entries stay at reset value
            for (int r = 1; r < NREG; r++) begin
                if (accept && dst_we && (dst == AW'(r))) begin
                    cnt[r]  <= cnt_init;
                    age[r]  <= FW'(1);
                    pend[r] <= 1'b1;
                end else if (pend[r]) begin
                    if (cnt[r] != '0) begin
                        cnt[r] <= cnt[r] - LW'(1);
                    end
                    if (age[r] == FW'(PIPE_DEPTH)) begin
                        pend[r] <= 1'b0;
                        age[r]  <= '0;
                    end else begin
                        age[r] <= age[r] + FW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: doc/pipe_hazard_scoreboard.md
Name: pipe_hazard_scoreboard

Overview:
- Parametrised in-order hazard and forwarding controller for the pipelined MIPS core.
- Replaces the fixed load-use detect and two-stage forward logic with a per-register scoreboard.
- Supports a configurable register count, pipeline depth and per-instruction result latency (ALU, load, multi-cycle ops).
- Sits at the ID stage: tells the datapath when to stall issue and which later stage each source operand must be forwarded from.

Parameters:
- NREG, 32: number of architectural registers; register 0 is hard-wired zero and never tracked.
- AW, $clog2(NREG): register index width.
- PIPE_DEPTH, 3: stages after ID up to and including WB (EX, MEM, WB).
- MAX_LAT, 3: largest legal result latency; must be ≤ PIPE_DEPTH.
- LW, $clog2(MAX_LAT+1): latency field width.
- FW, $clog2(PIPE_DEPTH+1): forward-select width.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous reset, active-low.
- issue_valid, in, 1: an instruction is present in ID.
- flush, in, 1: squash the ID instruction this cycle (branch/jump taken).
- src_a, in, AW: rs index.
- use_a, in, 1: instruction reads rs.
- src_b, in, AW: rt index.
- use_b, in, 1: instruction reads rt.
- dst, in, AW: destination register.
- dst_we, in, 1: instruction writes dst.
- lat, in, LW: cycles until the result can be forwarded (1 = ALU, 2 = load); 0 is treated as 1.
- stall, out, 1: hold PC and IF/ID, insert bubble into ID/EX.
- fwd_sel_a, out, FW: rs source; 0 = register file, k = producer currently k stages past ID.
- fwd_sel_b, out, FW: same for rt.
- pending_cnt, out, AW+1: number of registers with an in-flight write.
- stall_cycles, out, 32: saturating count of stall cycles.

Behaviour:
- State per register r (1..NREG-1):
  - cnt[r], LW bits: remaining issue-blocking cycles.
  - age[r], FW bits: stages past ID.
  - pend[r]: write in flight.
- Reset (rst low, async): all cnt, age and pend are 0; stall_cycles is 0; pending_cnt is 0. A reset mid-operation discards all in-flight tracking immediately.
- stall (combinational) = issue_valid & (hit_a | hit_b).
  - hit_x = use_x & (src_x != 0) & (cnt[src_x] != 0).
  - flush does not mask stall.
- accept = issue_valid & !stall & !flush.
- Per clock, for each r != 0:
  - If accept & dst_we & dst == r & r != 0:
    - cnt[r] <= max(lat,1) - 1
    - age[r] <= 1
    - pend[r] <= 1
    - The newest producer overwrites any older pending entry for r.
  - Else if pend[r]:
    - cnt[r] <= cnt[r] - 1, saturating at 0.
    - If age[r] == PIPE_DEPTH: pend[r] <= 0 and age[r] <= 0 (written back).
    - Otherwise age[r] <= age[r] + 1.
- fwd_sel_x (combinational):
  - (use_x & src_x != 0 & pend[src_x]) ? age[src_x] : 0.
  - It is valid even when stall = 1; the datapath registers it only on accept.
- Same-cycle read of a register being written by the issuing instruction uses pre-update state (the instruction reads the old value).
- A stalled instruction is not recorded. A flushed instruction is not recorded. A bubble (issue_valid = 0) is not recorded.
- pending_cnt = popcount(pend), combinational from registered state.
- stall_cycles increments by 1 on each clock where stall & !flush; it holds at 32'hFFFFFFFF.
- Resulting timing for the default configuration:
  - ALU → dependent back-to-back: 0 bubbles, fwd_sel 1 (EX/MEM path next cycle).
  - Load → dependent: 1 bubble, then fwd_sel 2.
  - lat = 3 → 2 bubbles.

Test Plan:
1. Reset then idle: rst low mid-run with 3 pending regs → all outputs 0 immediately; after release, stall = 0 for any sources.
2. ALU chain: issue dst = 8, lat = 1; next cycle src_a = 8 → stall 0, fwd_sel_a 1; following cycle src_b = 8 → fwd_sel_b 2; one cycle later → 3; then 0, pending_cnt back to 0.
3. Load-use: issue dst = 9, lat = 2; next cycle src_a = 9 → stall 1 for exactly one cycle, stall_cycles = 1; then stall 0, fwd_sel_a 2.
4. lat = 3 dependent on src_b → two stall cycles. Same case with use_b = 0 → no stall. Same case with src_b = 0 → no stall.
5. WAW overwrite: issue dst = 5, lat = 3, then dst = 5, lat = 1 on the next cycle → scoreboard follows the newer producer: age 1, and a dependent issues with no stall.
6. Flush: issue_valid = 1, flush = 1, dst = 7, dst_we = 1 → no entry created (pending_cnt unchanged). A flush during a stall does not increment stall_cycles.
